usb_hub_port_arbiter: RTL and testbench
=======================================

// Module: usb_hub_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares the hub's single upstream (host) transmit
//  path among NUM_USB_DEVICES downstream ports. Grants one port at a time and
//  holds the grant until that port signals end-of-packet. Enforces an
//  inter-packet gap between grants. Sits between the downstream port PHY/SIE
//  instances and the upstream mux inside usb_hub_top.
// PARAMETERS
//  NUM_USB_DEVICES  16    number of downstream ports (requesters), >=2
//  IPG_CYCLES       2     idle gap cycles after each release, >=1
//  MAX_HOLD_CYCLES  1024  hold-watchdog limit, only with USB_HUB_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1      single clock; all logic is on the rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  port_req     in   N      per-port request for the upstream path
//  port_eop     in   N      per-port end-of-packet pulse from the granted port
//  port_en      in   N      per-port enable mask; 0 = port ignored or released
//  grant        out  N      one-hot grant, registered
//  grant_valid  out  1      high while any grant bit is set
//  grant_idx    out  clog2(N)  index of current or last granted port
//  timeout_err  out  1      1-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset (async, immediate): grant=0, grant_valid=0, grant_idx=0,
//   timeout_err=0, state=IDLE, rr pointer=0 (port 0 has highest priority).
//  FSM states: IDLE, BUSY, GAP.
//  IDLE: eligible = port_req & port_en. If eligible!=0, pick the first set bit
//   at or above ptr, wrapping N-1 -> 0. On the next edge: grant=onehot(pick),
//   grant_idx=pick, grant_valid=1, go to BUSY. Req-to-grant latency is 1 edge.
//   If eligible==0, stay in IDLE.
//  BUSY: grant is held. port_req is not sampled, so a dropped req does not
//   release. port_eop on non-granted ports is ignored.
//   - port_eop[grant_idx]=1 -> next edge: grant=0, grant_valid=0,
//     ptr=(grant_idx+1) mod N, go to GAP.
//   - port_en[grant_idx]=0 -> same release, no error. If it coincides with
//     eop, it is treated as a normal release.
//  GAP: the counter runs IPG_CYCLES edges with grant=0, then goes to IDLE.
//   For eop sampled at edge k, the next grant rises at edge k+IPG_CYCLES+1.
//   grant is therefore low for IPG_CYCLES+1 cycles minimum.
//  grant_idx keeps the last granted value while grant_valid=0.
//  A lone repeating requester is re-granted each round (wrap-around is fair).
//  At most one grant bit is set in any cycle. grant_valid == |grant.
//  Reset asserted mid-BUSY drops grant asynchronously. No eop is required.
// CONFIGURATION
//  USB_HUB_ARB_TIMEOUT_EN defined:
//   - A hold counter (clog2(MAX_HOLD_CYCLES+1) bits) clears on entry to BUSY
//     and increments each BUSY cycle.
//   - If it reaches MAX_HOLD_CYCLES with no eop, release as for eop (ptr
//     advances, go to GAP) and pulse timeout_err for that same edge.
//   - eop on the limit cycle wins; timeout_err is not raised.
//  USB_HUB_ARB_TIMEOUT_EN undefined: no counter, timeout_err is tied to 0, and
//   a grant is held indefinitely until eop, en drop, or reset.
// TESTING (N=16, IPG_CYCLES=2, port_en=16'hFFFF unless stated)
//  1. Reset, then port_req=16'h0001 -> one edge later grant=16'h0001,
//     grant_idx=0, grant_valid=1.
//  2. port_req=16'h8001 -> port 0 granted first. eop[0] -> grant=0 for 3
//     cycles, then grant=16'h8000, grant_idx=15.
//  3. port_req=16'hFFFF, eop 4 cycles after each grant -> grant_idx sequence
//     0,1,...,15,0. No port is granted twice before all others.
//  4. Port 5 granted, then port_en[5]=0 -> grant=0 next edge, timeout_err=0.
//     port_req=16'h0020 with port_en=16'hFFDF -> no grant.
//  5. With the macro and MAX_HOLD_CYCLES=16: port 3 granted with no eop ->
//     release after 16 BUSY cycles, timeout_err high 1 cycle. Without the
//     macro, grant is still held after 1000 cycles.
//  6. rst_n low mid-BUSY -> grant=0 before the next clk edge. After reset,
//     port_req=16'h0004 -> grant=16'h0004 one edge later.

Source files
------------

// File: rtl/usb_hub_port_arbiter_if.sv
// Request/grant bundle between the downstream ports and the upstream-path arbiter.
interface usb_hub_port_arbiter_if #(
  parameter int N = 16
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  port_req;
  logic [N-1:0]  port_eop;
  logic [N-1:0]  port_en;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          timeout_err;

  modport master (
    output port_req, port_eop, port_en,
    input  grant, grant_valid, grant_idx, timeout_err
  );

  modport slave (
    input  port_req, port_eop, port_en,
    output grant, grant_valid, grant_idx, timeout_err
  );
endinterface

// File: rtl/usb_hub_port_arbiter.sv
// Round-robin owner of the hub upstream transmit path: one-hot grant held until eop.
// Optional hold watchdog enabled by defining USB_HUB_ARB_TIMEOUT_EN.
module usb_hub_port_arbiter #(
  parameter int NUM_USB_DEVICES = 16,
  parameter int IPG_CYCLES      = 2,
  parameter int MAX_HOLD_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    rst_n,
  usb_hub_port_arbiter_if.slave  arb_if
);
  localparam int N  = NUM_USB_DEVICES;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [N-1:0]  elig;
  logic [IW-1:0] pick;
  logic          found;
  logic          tmo_hit;
  logic          tmo_d;
  logic          rel;

`ifdef USB_HUB_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          tmo_q;
`endif

  assign elig = arb_if.port_req & arb_if.port_en;

  // First eligible port at or above the pointer, wrapping past N-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    tmo_hit = 1'b0;
    tmo_d   = 1'b0;
    rel     = 1'b0;
`ifdef USB_HUB_ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        grant_d = N'(1) << pick;
        idx_d   = pick;
        state_d = BUSY;
`ifdef USB_HUB_ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end
      BUSY: begin
`ifdef USB_HUB_ARB_TIMEOUT_EN
        hold_d  = hold_q + 1'b1;
        tmo_hit = (hold_q == HW'(MAX_HOLD_CYCLES - 1));
`endif
        rel = arb_if.port_eop[idx_q] || !arb_if.port_en[idx_q] || tmo_hit;
        if (rel) begin
          grant_d = '0;
          ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          gap_d   = '0;
          state_d = GAP;
          // A genuine eop or enable drop on the limit cycle is not an error.
          tmo_d   = tmo_hit && !arb_if.port_eop[idx_q] && arb_if.port_en[idx_q];
        end
      end
      GAP: begin
        if (gap_q == GW'(IPG_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
    end
  end

`ifdef USB_HUB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tmo_q  <= tmo_d;
    end
  end
  assign arb_if.timeout_err = tmo_q;
`else
  assign arb_if.timeout_err = 1'b0;
`endif

  assign arb_if.grant       = grant_q;
  assign arb_if.grant_valid = |grant_q;
  assign arb_if.grant_idx   = idx_q;
endmodule

// File: tb/tb_usb_hub_port_arbiter.sv
// Scoreboard bench: driver predicts each grant (port, edge) from the round-robin rules;
// a negedge monitor pops and compares whenever a grant rises.
module tb_usb_hub_port_arbiter;
  localparam int N    = 16;
  localparam int IPG  = 2;
  localparam int MAXH = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int idx;
    int edge_no;
  } exp_t;
  exp_t exp_q[$];

  int   m_ptr;
  int   m_rel;
  logic prev_gv;

  usb_hub_port_arbiter_if #(.N(N)) arb_if ();

  usb_hub_port_arbiter #(
    .NUM_USB_DEVICES (N),
    .IPG_CYCLES      (IPG),
    .MAX_HOLD_CYCLES (MAXH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_pick(logic [N-1:0] e, int p);
    for (int k = 0; k < N; k++)
      if (e[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Monitor: structural invariants every cycle, scoreboard compare on each new grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gv = 1'b0;
    end else begin
      checks++;
      if (arb_if.grant_valid !== (|arb_if.grant) || !$onehot0(arb_if.grant)) begin
        errors++;
        $display("FAIL invariant cyc=%0d grant=%h grant_valid=%b", cyc, arb_if.grant, arb_if.grant_valid);
      end
      if (arb_if.grant_valid === 1'b1 && !prev_gv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant cyc=%0d grant=%h", cyc, arb_if.grant);
        end else begin
          exp_t e;
          logic [N-1:0] oh;
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          if (arb_if.grant_idx !== 4'(e.idx) || arb_if.grant !== oh || cyc != e.edge_no) begin
            errors++;
            $display("FAIL grant cyc=%0d idx=%0d grant=%h expected cyc=%0d idx=%0d grant=%h",
                     cyc, arb_if.grant_idx, arb_if.grant, e.edge_no, e.idx, oh);
          end
        end
      end
      prev_gv = arb_if.grant_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic do_reset();
    arb_if.port_req = '0;
    arb_if.port_eop = '0;
    arb_if.port_en  = '1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(arb_if.grant), 32'h0);
    chk("rst_gv", 32'(arb_if.grant_valid), 32'h0);
    chk("rst_idx", 32'(arb_if.grant_idx), 32'h0);
    chk("rst_tmo", 32'(arb_if.timeout_err), 32'h0);
    rst_n = 1'b1;
    m_ptr = 0;
    m_rel = -1000;
  endtask

  // Called at a negedge; presents req/en and waits (bounded) for the grant to rise.
  task automatic request(input logic [N-1:0] req, input logic [N-1:0] en, input int pre_idle,
                         output int idx, output bit ok);
    int s, e;
    exp_t x;
    repeat (pre_idle) @(negedge clk);
    arb_if.port_req = req;
    arb_if.port_en  = en;
    s   = cyc + 1;
    idx = model_pick(req & en, m_ptr);
    e   = (s > m_rel + IPG + 1) ? s : m_rel + IPG + 1;
    x.idx = idx;
    x.edge_no = e;
    exp_q.push_back(x);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (arb_if.grant_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout cyc=%0d actual=no_grant required=port%0d", cyc, idx);
      void'(exp_q.pop_front());
    end
  endtask

  // Hold with noise on requests and other ports' eop, then release by eop or enable drop.
  task automatic hold_release(input int idx, input int hold, input bit drop);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      arb_if.port_req = N'($urandom);
      arb_if.port_eop = N'($urandom) & ~oh;
      arb_if.port_en  = N'($urandom) | oh;
      @(negedge clk);
    end
    chk("held_grant", 32'(arb_if.grant), 32'(oh));
    if (drop) begin
      arb_if.port_en  = ~oh;
      arb_if.port_eop = N'($urandom) & ~oh;
    end else begin
      arb_if.port_en  = N'($urandom) | oh;
      arb_if.port_eop = N'($urandom) | oh;
    end
    @(negedge clk);
    m_rel = cyc;
    m_ptr = (idx + 1) % N;
    chk("rel_gv", 32'(arb_if.grant_valid), 32'h0);
    chk("rel_tmo", 32'(arb_if.timeout_err), 32'h0);
    chk("rel_idx", 32'(arb_if.grant_idx), 32'(idx));
    arb_if.port_req = '0;
    arb_if.port_eop = '0;
    arb_if.port_en  = '1;
  endtask

  initial begin
    int  idx;
    bit  ok;
    logic [N-1:0] rq, en;
    checks = 0;
    errors = 0;
    prev_gv = 1'b0;
    rst_n = 1'b0;
    arb_if.port_req = '0;
    arb_if.port_eop = '0;
    arb_if.port_en  = '1;
    @(negedge clk);
    do_reset();

    // Single requester after reset, one edge latency.
    request(16'h0001, 16'hFFFF, 0, idx, ok);
    if (ok) hold_release(idx, 2, 1'b0);
    do_reset();

    // Port 0 first, then port 15 after the gap.
    request(16'h8001, 16'hFFFF, 0, idx, ok);
    if (ok) hold_release(idx, 1, 1'b0);
    request(16'h8001 & ~16'h0001, 16'hFFFF, 0, idx, ok);
    if (ok) hold_release(idx, 1, 1'b0);

    // Full round with every port requesting.
    for (int t = 0; t < N + 1; t++) begin
      request(16'hFFFF, 16'hFFFF, 0, idx, ok);
      if (ok) hold_release(idx, 3, 1'b0);
    end

    // Enable drop releases without error; masked requester never granted.
    request(16'h0020, 16'hFFFF, 0, idx, ok);
    if (ok) hold_release(idx, 2, 1'b1);
    arb_if.port_req = 16'h0020;
    arb_if.port_en  = 16'hFFDF;
    repeat (10) @(negedge clk);
    chk("masked_gv", 32'(arb_if.grant_valid), 32'h0);
    arb_if.port_req = '0;
    arb_if.port_en  = '1;

`ifdef USB_HUB_ARB_TIMEOUT_EN
    request(16'h0008, 16'hFFFF, 0, idx, ok);
    if (ok) begin
      int g;
      g = cyc;
      for (int k = 0; k < 40; k++) begin
        if (arb_if.grant_valid !== 1'b1) break;
        @(negedge clk);
      end
      chk("tmo_edge", 32'(cyc), 32'(g + MAXH));
      chk("tmo_pulse", 32'(arb_if.timeout_err), 32'h1);
      m_rel = cyc;
      m_ptr = (idx + 1) % N;
      @(negedge clk);
      chk("tmo_pulse_end", 32'(arb_if.timeout_err), 32'h0);
    end
`else
    request(16'h0008, 16'hFFFF, 0, idx, ok);
    if (ok) hold_release(idx, 1000, 1'b0);
`endif

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      en = N'($urandom);
      if (en == '0) en = '1;
      rq = N'($urandom);
      if ((rq & en) == '0) rq = en;
      request(rq, en, $urandom_range(0, 3), idx, ok);
      if (ok) hold_release(idx, $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset while a grant is held.
    request(16'h0002, 16'hFFFF, 0, idx, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(arb_if.grant), 32'h0);
    chk("async_rst_gv", 32'(arb_if.grant_valid), 32'h0);
    chk("async_rst_idx", 32'(arb_if.grant_idx), 32'h0);
    arb_if.port_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_rel = -1000;
    request(16'h0004, 16'hFFFF, 0, idx, ok);
    if (ok) hold_release(idx, 2, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
